// File: rtl/axi3_pkg.sv
// Shared AXI3 constants and FSM state types for the OCM responder.
package axi3_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/ocm_dpram.sv
// Simple dual-port word RAM: byte-masked write port, registered read port.
// Both ports share one clock; a same-address read and write returns the old word.
module ocm_dpram #(
    parameter int addr_width = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  re,
    input  logic [addr_width-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << addr_width) - 1];

    // Byte-lane masked write; lanes with a clear strobe keep their old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; holds its value whenever no read is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi3_ocm_responder.sv
// AXI3 slave backed by an on-chip word RAM. Independent write (AW/W/B) and
// read (AR/R) FSMs, one burst in flight per direction.
module axi3_ocm_responder
    import axi3_pkg::*;
#(
    parameter logic [31:0] ocm_haddr = 32'hfffc0000,
    parameter int          ocm_width = 16
) (
    input  logic        AXI_clk,
    input  logic        rst,
    input  logic [31:0] AXI_awaddr,
    input  logic [11:0] AXI_awid,
    input  logic [3:0]  AXI_awlen,
    input  logic [2:0]  AXI_awsize,
    input  logic [1:0]  AXI_awburst,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,
    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    input  logic        AXI_wlast,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,
    output logic [11:0] AXI_bid,
    output logic [1:0]  AXI_bresp,
    output logic        AXI_bvalid,
    input  logic        AXI_bready,
    input  logic [31:0] AXI_araddr,
    input  logic [11:0] AXI_arid,
    input  logic [3:0]  AXI_arlen,
    input  logic [2:0]  AXI_arsize,
    input  logic [1:0]  AXI_arburst,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,
    output logic [31:0] AXI_rdata,
    output logic [11:0] AXI_rid,
    output logic [1:0]  AXI_rresp,
    output logic        AXI_rlast,
    output logic        AXI_rvalid,
    input  logic        AXI_rready,
    output logic        err
);

    localparam int word_width = ocm_width - 2;

    // A burst is bad if it falls outside the window or uses an unsupported size/type.
    function automatic logic header_bad(input logic [31:0] addr,
                                        input logic [2:0]  size,
                                        input logic [1:0]  burst);
        return (addr[31:ocm_width] != ocm_haddr[31:ocm_width]) ||
               (size != SIZE_4B) ||
               ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    w_state_t              w_state;
    logic [word_width-1:0] w_addr;
    logic [3:0]            w_len;
    logic                  w_fixed;
    logic                  w_hdr_bad;
    logic [4:0]            w_cnt;
    logic                  w_err_flag;

    r_state_t              r_state;
    logic [word_width-1:0] r_addr;
    logic [3:0]            r_len;
    logic                  r_fixed;
    logic                  r_hdr_bad;
    logic [3:0]            r_cnt;
    logic                  r_err_flag;

    logic                  w_beat;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_q;

    wire unused_addr_bits = ^{AXI_awaddr[1:0], AXI_araddr[1:0]};

    assign w_beat = (w_state == W_DATA) && AXI_wvalid && AXI_wready;
    assign ram_we = w_beat && !w_hdr_bad && (w_cnt <= {1'b0, w_len});
    assign ram_re = (r_state == R_FETCH);

    assign AXI_rdata = (AXI_rvalid && !r_hdr_bad) ? ram_q : 32'h0;
    assign err       = w_err_flag | r_err_flag;

    ocm_dpram #(
        .addr_width(word_width)
    ) u_ram (
        .clk   (AXI_clk),
        .we    (ram_we),
        .waddr (w_addr),
        .wdata (AXI_wdata),
        .wstrb (AXI_wstrb),
        .re    (ram_re),
        .raddr (r_addr),
        .rdata (ram_q)
    );

    // Write FSM: accept AW, absorb W beats into the RAM, then hold B until taken.
    always_ff @(posedge AXI_clk or negedge rst) begin
        if (!rst) begin
            w_state     <= W_IDLE;
            w_addr      <= '0;
            w_len       <= '0;
            w_fixed     <= 1'b0;
            w_hdr_bad   <= 1'b0;
            w_cnt       <= '0;
            w_err_flag  <= 1'b0;
            AXI_awready <= 1'b0;
            AXI_wready  <= 1'b0;
            AXI_bvalid  <= 1'b0;
            AXI_bid     <= '0;
            AXI_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AXI_awvalid && AXI_awready) begin
                        w_addr      <= AXI_awaddr[ocm_width-1:2];
                        w_len       <= AXI_awlen;
                        w_fixed     <= (AXI_awburst == BURST_FIXED);
                        w_hdr_bad   <= header_bad(AXI_awaddr, AXI_awsize, AXI_awburst);
                        w_cnt       <= '0;
                        AXI_bid     <= AXI_awid;
                        AXI_awready <= 1'b0;
                        AXI_wready  <= 1'b1;
                        w_state     <= W_DATA;
                    end else begin
                        AXI_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        if (!w_fixed) begin
                            w_addr <= w_addr + 1'b1;
                        end
                        if (w_cnt != 5'd16) begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                        if (AXI_wlast) begin
                            AXI_wready <= 1'b0;
                            AXI_bvalid <= 1'b1;
                            if (w_hdr_bad || (w_cnt != {1'b0, w_len})) begin
                                AXI_bresp  <= RESP_SLVERR;
                                w_err_flag <= 1'b1;
                            end else begin
                                AXI_bresp <= RESP_OKAY;
                            end
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (AXI_bready) begin
                        AXI_bvalid  <= 1'b0;
                        AXI_awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: alternate RAM fetch and R presentation, one beat every two cycles.
    always_ff @(posedge AXI_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_fixed     <= 1'b0;
            r_hdr_bad   <= 1'b0;
            r_cnt       <= '0;
            r_err_flag  <= 1'b0;
            AXI_arready <= 1'b0;
            AXI_rvalid  <= 1'b0;
            AXI_rid     <= '0;
            AXI_rresp   <= RESP_OKAY;
            AXI_rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (AXI_arvalid && AXI_arready) begin
                        r_addr      <= AXI_araddr[ocm_width-1:2];
                        r_len       <= AXI_arlen;
                        r_fixed     <= (AXI_arburst == BURST_FIXED);
                        r_hdr_bad   <= header_bad(AXI_araddr, AXI_arsize, AXI_arburst);
                        r_cnt       <= '0;
                        AXI_rid     <= AXI_arid;
                        AXI_arready <= 1'b0;
                        r_state     <= R_FETCH;
                    end else begin
                        AXI_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    AXI_rvalid <= 1'b1;
                    AXI_rlast  <= (r_cnt == r_len);
                    if (r_hdr_bad) begin
                        AXI_rresp  <= RESP_SLVERR;
                        r_err_flag <= 1'b1;
                    end else begin
                        AXI_rresp <= RESP_OKAY;
                    end
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (AXI_rready) begin
                        AXI_rvalid <= 1'b0;
                        AXI_rlast  <= 1'b0;
                        if (r_cnt == r_len) begin
                            AXI_arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (!r_fixed) begin
                                r_addr <= r_addr + 1'b1;
                            end
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_ocm_responder.sv
// Directed scoreboard bench for axi3_ocm_responder.
module tb_axi3_ocm_responder;
    import axi3_pkg::*;

    typedef struct packed {
        logic [11:0] id;
        logic [1:0]  resp;
    } b_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [11:0] id;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] AXI_awaddr;
    logic [11:0] AXI_awid;
    logic [3:0]  AXI_awlen;
    logic [2:0]  AXI_awsize;
    logic [1:0]  AXI_awburst;
    logic        AXI_awvalid;
    logic        AXI_awready;
    logic [31:0] AXI_wdata;
    logic [3:0]  AXI_wstrb;
    logic        AXI_wlast;
    logic        AXI_wvalid;
    logic        AXI_wready;
    logic [11:0] AXI_bid;
    logic [1:0]  AXI_bresp;
    logic        AXI_bvalid;
    logic        AXI_bready;
    logic [31:0] AXI_araddr;
    logic [11:0] AXI_arid;
    logic [3:0]  AXI_arlen;
    logic [2:0]  AXI_arsize;
    logic [1:0]  AXI_arburst;
    logic        AXI_arvalid;
    logic        AXI_arready;
    logic [31:0] AXI_rdata;
    logic [11:0] AXI_rid;
    logic [1:0]  AXI_rresp;
    logic        AXI_rlast;
    logic        AXI_rvalid;
    logic        AXI_rready;
    logic        err;

    int checks = 0;
    int errors = 0;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] rd_exp [16];

    localparam int GUARD = 200;

    always #5 clk = ~clk;

    axi3_ocm_responder dut (
        .AXI_clk     (clk),
        .rst         (rst_n),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awid    (AXI_awid),
        .AXI_awlen   (AXI_awlen),
        .AXI_awsize  (AXI_awsize),
        .AXI_awburst (AXI_awburst),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wdata   (AXI_wdata),
        .AXI_wstrb   (AXI_wstrb),
        .AXI_wlast   (AXI_wlast),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wready  (AXI_wready),
        .AXI_bid     (AXI_bid),
        .AXI_bresp   (AXI_bresp),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bready  (AXI_bready),
        .AXI_araddr  (AXI_araddr),
        .AXI_arid    (AXI_arid),
        .AXI_arlen   (AXI_arlen),
        .AXI_arsize  (AXI_arsize),
        .AXI_arburst (AXI_arburst),
        .AXI_arvalid (AXI_arvalid),
        .AXI_arready (AXI_arready),
        .AXI_rdata   (AXI_rdata),
        .AXI_rid     (AXI_rid),
        .AXI_rresp   (AXI_rresp),
        .AXI_rlast   (AXI_rlast),
        .AXI_rvalid  (AXI_rvalid),
        .AXI_rready  (AXI_rready),
        .err         (err)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout after %0d cycles, expected handshake", name, GUARD);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for B: pops one expectation per handshake, checks stability while stalled.
    initial begin : b_monitor
        logic         hold;
        logic [13:0]  prev;
        b_exp_t       e;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else if (AXI_bvalid) begin
                if (hold) check_output("b_stable", {AXI_bid, AXI_bresp}, prev);
                if (AXI_bready) begin
                    if (b_q.size() == 0) begin
                        check_output("b_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = b_q.pop_front();
                        check_output("b_resp", {AXI_bid, AXI_bresp}, e);
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    prev = {AXI_bid, AXI_bresp};
                end
            end else if (hold) begin
                check_output("b_valid_dropped", AXI_bvalid, 1'b1);
                hold = 1'b0;
            end
        end
    end

    // Monitor for R: pops one expectation per beat, checks stability while stalled.
    initial begin : r_monitor
        logic         hold;
        logic [46:0]  prev;
        r_exp_t       e;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else if (AXI_rvalid) begin
                if (hold) check_output("r_stable", {AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast}, prev);
                if (AXI_rready) begin
                    if (r_q.size() == 0) begin
                        check_output("r_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = r_q.pop_front();
                        check_output("r_beat", {AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast}, e);
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    prev = {AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast};
                end
            end else if (hold) begin
                check_output("r_valid_dropped", AXI_rvalid, 1'b1);
                hold = 1'b0;
            end
        end
    end

    // Drive one write burst (data = base + beat) and queue the expected B response.
    task automatic write_burst(input logic [31:0] addr, input logic [11:0] id,
                               input logic [3:0] len, input logic [1:0] burst,
                               input logic [2:0] size, input logic [31:0] base,
                               input logic [3:0] strb, input int nbeats,
                               input int last_beat, input logic [1:0] resp,
                               input int b_stall);
        int     guard;
        b_exp_t e;
        e.id   = id;
        e.resp = resp;
        b_q.push_back(e);
        AXI_bready  = (b_stall == 0);
        AXI_awaddr  = addr;
        AXI_awid    = id;
        AXI_awlen   = len;
        AXI_awburst = burst;
        AXI_awsize  = size;
        AXI_awvalid = 1'b1;
        guard = 0;
        while (!AXI_awready && guard < GUARD) begin tick(); guard++; end
        if (guard >= GUARD) report_timeout("aw_handshake");
        tick();
        AXI_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            AXI_wdata  = base + i;
            AXI_wstrb  = strb;
            AXI_wlast  = (i == last_beat);
            AXI_wvalid = 1'b1;
            guard = 0;
            while (!AXI_wready && guard < GUARD) begin tick(); guard++; end
            if (guard >= GUARD) report_timeout("w_handshake");
            tick();
        end
        AXI_wvalid = 1'b0;
        AXI_wlast  = 1'b0;
        guard = 0;
        while (!AXI_bvalid && guard < GUARD) begin tick(); guard++; end
        if (guard >= GUARD) report_timeout("b_wait");
        else check_output("b_latency", guard, 0);
        if (b_stall > 0) begin
            repeat (b_stall) tick();
            AXI_bready = 1'b1;
        end
        tick();
    endtask

    // Drive one read burst; expected data comes from rd_exp, zero on SLVERR.
    task automatic read_burst(input logic [31:0] addr, input logic [11:0] id,
                              input logic [3:0] len, input logic [1:0] burst,
                              input logic [2:0] size, input logic [1:0] resp,
                              input int stall_beat, input int stall_cycles);
        int     guard;
        r_exp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = (resp == RESP_OKAY) ? rd_exp[i] : 32'h0;
            e.id   = id;
            e.resp = resp;
            e.last = (i == int'(len));
            r_q.push_back(e);
        end
        AXI_rready  = 1'b1;
        AXI_araddr  = addr;
        AXI_arid    = id;
        AXI_arlen   = len;
        AXI_arburst = burst;
        AXI_arsize  = size;
        AXI_arvalid = 1'b1;
        guard = 0;
        while (!AXI_arready && guard < GUARD) begin tick(); guard++; end
        if (guard >= GUARD) report_timeout("ar_handshake");
        tick();
        AXI_arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            guard = 0;
            while (!AXI_rvalid && guard < GUARD) begin tick(); guard++; end
            if (guard >= GUARD) begin
                report_timeout("r_wait");
            end else begin
                check_output("r_beat_latency", guard, 1);
            end
            if (i == stall_beat) begin
                AXI_rready = 1'b0;
                repeat (stall_cycles) tick();
                AXI_rready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic apply_stimulus();
        int guard;
        // Reset values while reset is held.
        check_output("rst_ready", {AXI_awready, AXI_wready, AXI_arready}, 3'b000);
        check_output("rst_valid", {AXI_bvalid, AXI_rvalid, AXI_rlast, err}, 4'b0000);
        check_output("rst_ids", {AXI_bid, AXI_rid, AXI_bresp, AXI_rresp}, 28'h0);
        check_output("rst_rdata", AXI_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        check_output("awready_after_rst", AXI_awready, 1'b1);

        // 16-beat INCR write with a 5-cycle B stall, read back with a 3-cycle stall on beat 7.
        write_burst(32'hfffc0000, 12'h1a5, 4'd15, BURST_INCR, SIZE_4B, 32'd0, 4'hf, 16, 15, RESP_OKAY, 5);
        for (int i = 0; i < 16; i++) rd_exp[i] = i;
        read_burst(32'hfffc0000, 12'h2b6, 4'd15, BURST_INCR, SIZE_4B, RESP_OKAY, 7, 3);

        // Partial strobe over a preset word.
        write_burst(32'hfffc0010, 12'h003, 4'd0, BURST_INCR, SIZE_4B, 32'hffffffff, 4'hf, 1, 0, RESP_OKAY, 0);
        write_burst(32'hfffc0010, 12'h004, 4'd0, BURST_INCR, SIZE_4B, 32'h11223344, 4'b0101, 1, 0, RESP_OKAY, 0);
        rd_exp[0] = 32'hff22ff44;
        read_burst(32'hfffc0010, 12'h005, 4'd0, BURST_INCR, SIZE_4B, RESP_OKAY, -1, 0);
        check_output("err_clean", err, 1'b0);

        // Out-of-window write must not alias onto the window word at the same offset.
        write_burst(32'hfffc1000, 12'h006, 4'd0, BURST_INCR, SIZE_4B, 32'ha5a5a5a5, 4'hf, 1, 0, RESP_OKAY, 0);
        write_burst(32'h00001000, 12'h007, 4'd0, BURST_INCR, SIZE_4B, 32'hdeadbeef, 4'hf, 1, 0, RESP_SLVERR, 0);
        check_output("err_after_slverr", err, 1'b1);
        rd_exp[0] = 32'ha5a5a5a5;
        read_burst(32'hfffc1000, 12'h008, 4'd0, BURST_INCR, SIZE_4B, RESP_OKAY, -1, 0);
        read_burst(32'h00001000, 12'h009, 4'd3, BURST_INCR, SIZE_4B, RESP_SLVERR, -1, 0);

        // INCR wraps inside the window.
        write_burst(32'hfffcfff8, 12'h00a, 4'd3, BURST_INCR, SIZE_4B, 32'h100, 4'hf, 4, 3, RESP_OKAY, 0);
        rd_exp[0] = 32'h100; rd_exp[1] = 32'h101; rd_exp[2] = 32'h102; rd_exp[3] = 32'h103;
        read_burst(32'hfffcfff8, 12'h00b, 4'd3, BURST_INCR, SIZE_4B, RESP_OKAY, -1, 0);
        rd_exp[0] = 32'h102; rd_exp[1] = 32'h103;
        read_burst(32'hfffc0000, 12'h00c, 4'd1, BURST_INCR, SIZE_4B, RESP_OKAY, -1, 0);

        // FIXED burst keeps hitting the same word; last beat wins.
        write_burst(32'hfffc0020, 12'h00d, 4'd2, BURST_FIXED, SIZE_4B, 32'h200, 4'hf, 3, 2, RESP_OKAY, 0);
        rd_exp[0] = 32'h202;
        read_burst(32'hfffc0020, 12'h00e, 4'd0, BURST_INCR, SIZE_4B, RESP_OKAY, -1, 0);

        // Bad size, bad burst type, and early wlast.
        write_burst(32'hfffc0030, 12'h00f, 4'd0, BURST_INCR, 3'b001, 32'h1, 4'hf, 1, 0, RESP_SLVERR, 0);
        read_burst(32'hfffc0030, 12'h010, 4'd1, 2'b10, SIZE_4B, RESP_SLVERR, -1, 0);
        write_burst(32'hfffc0100, 12'h011, 4'd3, BURST_INCR, SIZE_4B, 32'h300, 4'hf, 3, 2, RESP_SLVERR, 0);

        // Asynchronous reset in the middle of a read burst.
        rd_exp[0] = 32'h102; rd_exp[1] = 32'h103; rd_exp[2] = 32'h2; rd_exp[3] = 32'h3;
        rd_exp[4] = 32'hff22ff44; rd_exp[5] = 32'h5; rd_exp[6] = 32'h6; rd_exp[7] = 32'h7;
        for (int i = 0; i < 8; i++) begin
            r_exp_t e;
            e.data = rd_exp[i];
            e.id   = 12'h0ee;
            e.resp = RESP_OKAY;
            e.last = (i == 7);
            r_q.push_back(e);
        end
        AXI_rready  = 1'b1;
        AXI_araddr  = 32'hfffc0000;
        AXI_arid    = 12'h0ee;
        AXI_arlen   = 4'd7;
        AXI_arburst = BURST_INCR;
        AXI_arsize  = SIZE_4B;
        AXI_arvalid = 1'b1;
        guard = 0;
        while (!AXI_arready && guard < GUARD) begin tick(); guard++; end
        if (guard >= GUARD) report_timeout("ar_handshake_rst");
        tick();
        AXI_arvalid = 1'b0;
        repeat (4) tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", {AXI_rvalid, AXI_bvalid, AXI_rlast, err}, 4'b0000);
        check_output("async_rst_ready", {AXI_awready, AXI_wready, AXI_arready}, 3'b000);
        check_output("async_rst_rdata", AXI_rdata, 32'h0);
        check_output("beats_before_rst", r_q.size(), 6);
        r_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // A fresh burst after reset.
        write_burst(32'hfffc0040, 12'h0ab, 4'd1, BURST_INCR, SIZE_4B, 32'h55aa0000, 4'hf, 2, 1, RESP_OKAY, 0);
        rd_exp[0] = 32'h55aa0000; rd_exp[1] = 32'h55aa0001;
        read_burst(32'hfffc0040, 12'h0cd, 4'd1, BURST_INCR, SIZE_4B, RESP_OKAY, -1, 0);
        check_output("err_after_rst", err, 1'b0);
        repeat (3) tick();
        check_output("b_queue_empty", b_q.size(), 0);
        check_output("r_queue_empty", r_q.size(), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        AXI_awaddr  = '0;
        AXI_awid    = '0;
        AXI_awlen   = '0;
        AXI_awsize  = '0;
        AXI_awburst = '0;
        AXI_awvalid = 1'b0;
        AXI_wdata   = '0;
        AXI_wstrb   = '0;
        AXI_wlast   = 1'b0;
        AXI_wvalid  = 1'b0;
        AXI_bready  = 1'b1;
        AXI_araddr  = '0;
        AXI_arid    = '0;
        AXI_arlen   = '0;
        AXI_arsize  = '0;
        AXI_arburst = '0;
        AXI_arvalid = 1'b0;
        AXI_rready  = 1'b1;
        repeat (3) tick();
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
